// File: rtl/wave_sequencer.sv
// wave_sequencer
// Drives the waveform processor's phase ramp (count) and waveform select.
// The ramp advances once every freq+1 clock cycles. In auto mode the select
// steps to the next waveform after dwell+1 completed periods. New settings
// come in over a valid/ready handshake. While running they are held in a
// one-entry pending buffer and are only applied at a period wrap.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   start, stop       one-cycle run/stop requests (stop wins if both are high)
//   cfg_valid/ready   configuration handshake
//   cfg_freq          prescaler terminal value
//   cfg_select        waveform select
//   cfg_dwell         periods per select in auto mode, minus one
//   cfg_auto          auto-advance enable
//   count             phase ramp
//   select            waveform select
//   tick              count holds a freshly updated value
//   period_done       first cycle of count==0 after a wrap
//   busy              running or finishing the current period
module wave_sequencer #(
    parameter int CNT_W   = 8,
    parameter int PRE_W   = 8,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PRE_W-1:0]   cfg_freq,
    input  logic [2:0]         cfg_select,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               cfg_auto,
    output logic [CNT_W-1:0]   count,
    output logic [2:0]         select,
    output logic               tick,
    output logic               period_done,
    output logic               busy
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOPPING} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [DWELL_W-1:0] dw_q, dw_d;
    logic [PRE_W-1:0]   freq_q, freq_d;
    logic [2:0]         sel_q, sel_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               auto_q, auto_d;
    logic               pend_q, pend_d;
    logic [PRE_W-1:0]   pend_freq_q, pend_freq_d;
    logic [2:0]         pend_sel_q, pend_sel_d;
    logic [DWELL_W-1:0] pend_dwell_q, pend_dwell_d;
    logic               pend_auto_q, pend_auto_d;
    logic               tick_q, tick_d;
    logic               period_done_q, period_done_d;
    logic               busy_q, busy_d;
    logic               cfg_ready_q, cfg_ready_d;

    logic handshake;
    logic step;
    logic wrap;

    assign handshake = cfg_valid & cfg_ready_q;
    assign step      = (pre_q == freq_q);
    assign wrap      = step && (count_q == {CNT_W{1'b1}});

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        pre_d         = pre_q;
        dw_d          = dw_q;
        freq_d        = freq_q;
        sel_d         = sel_q;
        dwell_d       = dwell_q;
        auto_d        = auto_q;
        pend_d        = pend_q;
        pend_freq_d   = pend_freq_q;
        pend_sel_d    = pend_sel_q;
        pend_dwell_d  = pend_dwell_q;
        pend_auto_d   = pend_auto_q;
        tick_d        = 1'b0;
        period_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                count_d = '0;
                pre_d   = '0;
                // Nothing is playing, so a new setting can go live at once.
                if (handshake) begin
                    freq_d  = cfg_freq;
                    sel_d   = cfg_select;
                    dwell_d = cfg_dwell;
                    auto_d  = cfg_auto;
                    dw_d    = '0;
                end
                if (start && !stop) begin
                    state_d = S_RUN;
                end
            end

            default: begin
                if (step) begin
                    pre_d   = '0;
                    count_d = count_q + CNT_W'(1);
                    tick_d  = 1'b1;
                end else begin
                    pre_d = pre_q + PRE_W'(1);
                end

                if (wrap) begin
                    period_done_d = 1'b1;
                    // A pending setting overrides any auto-advance due now.
                    if (pend_q) begin
                        freq_d  = pend_freq_q;
                        sel_d   = pend_sel_q;
                        dwell_d = pend_dwell_q;
                        auto_d  = pend_auto_q;
                        pend_d  = 1'b0;
                        dw_d    = '0;
                    end else if (auto_q) begin
                        if (dw_q == dwell_q) begin
                            dw_d  = '0;
                            // Auto-advance cycles 0..6; code 7 only via config.
                            sel_d = (sel_q >= 3'd6) ? 3'd0 : sel_q + 3'd1;
                        end else begin
                            dw_d = dw_q + DWELL_W'(1);
                        end
                    end
                end

                // Evaluated after the wrap so that an offer taken on the wrap
                // edge is queued for the following period.
                if (handshake) begin
                    pend_d       = 1'b1;
                    pend_freq_d  = cfg_freq;
                    pend_sel_d   = cfg_select;
                    pend_dwell_d = cfg_dwell;
                    pend_auto_d  = cfg_auto;
                end

                if (state_q == S_RUN) begin
                    if (stop) begin
                        state_d = S_STOPPING;
                    end
                end else begin
                    if (start && !stop) begin
                        state_d = S_RUN;
                    end else if (wrap) begin
                        // count and pre are already 0 on a wrap step.
                        state_d = S_IDLE;
                    end
                end
            end
        endcase

        busy_d      = (state_d != S_IDLE);
        cfg_ready_d = (state_d == S_IDLE) ? 1'b1 : !pend_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            count_q       <= '0;
            pre_q         <= '0;
            dw_q          <= '0;
            freq_q        <= '0;
            sel_q         <= '0;
            dwell_q       <= '0;
            auto_q        <= 1'b0;
            pend_q        <= 1'b0;
            pend_freq_q   <= '0;
            pend_sel_q    <= '0;
            pend_dwell_q  <= '0;
            pend_auto_q   <= 1'b0;
            tick_q        <= 1'b0;
            period_done_q <= 1'b0;
            busy_q        <= 1'b0;
            cfg_ready_q   <= 1'b1;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            pre_q         <= pre_d;
            dw_q          <= dw_d;
            freq_q        <= freq_d;
            sel_q         <= sel_d;
            dwell_q       <= dwell_d;
            auto_q        <= auto_d;
            pend_q        <= pend_d;
            pend_freq_q   <= pend_freq_d;
            pend_sel_q    <= pend_sel_d;
            pend_dwell_q  <= pend_dwell_d;
            pend_auto_q   <= pend_auto_d;
            tick_q        <= tick_d;
            period_done_q <= period_done_d;
            busy_q        <= busy_d;
            cfg_ready_q   <= cfg_ready_d;
        end
    end

    assign count       = count_q;
    assign select      = sel_q;
    assign tick        = tick_q;
    assign period_done = period_done_q;
    assign busy        = busy_q;
    assign cfg_ready   = cfg_ready_q;

endmodule

// File: tb/tb_wave_sequencer.sv
// Directed testbench for wave_sequencer (default parameters).
module tb_wave_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_freq;
    logic [2:0] cfg_select;
    logic [7:0] cfg_dwell;
    logic       cfg_auto;
    logic [7:0] count;
    logic [2:0] select;
    logic       tick;
    logic       period_done;
    logic       busy;

    int pass_cnt = 0;
    int total_cnt = 0;

    wave_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_freq    (cfg_freq),
        .cfg_select  (cfg_select),
        .cfg_dwell   (cfg_dwell),
        .cfg_auto    (cfg_auto),
        .count       (count),
        .select      (select),
        .tick        (tick),
        .period_done (period_done),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_cfg(input logic [7:0] f, input logic [2:0] s,
                          input logic [7:0] d, input logic a);
        check("cfg_ready_idle", 32'(cfg_ready), 32'd1);
        cfg_valid  = 1'b1;
        cfg_freq   = f;
        cfg_select = s;
        cfg_dwell  = d;
        cfg_auto   = a;
        step();
        cfg_valid  = 1'b0;
        $display("cfg freq=%0d sel=%0d dwell=%0d auto=%0d -> select=%0d", f, s, d, a, select);
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        $display("start -> busy=%0d count=0x%0h", busy, count);
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
        $display("stop -> busy=%0d count=0x%0h", busy, count);
    endtask

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound && busy; i++) step();
        check("idle_reached", 32'(busy), 32'd0);
        check("idle_count", 32'(count), 32'd0);
    endtask

    initial begin
        int seq[7];
        int exp_cnt;
        seq = '{5, 5, 6, 6, 0, 0, 1};

        rst = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        cfg_valid = 1'b0;
        cfg_freq = '0;
        cfg_select = '0;
        cfg_dwell = '0;
        cfg_auto = 1'b0;
        repeat (3) step();
        check("rst_count", 32'(count), 32'd0);
        check("rst_select", 32'(select), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_pd", 32'(period_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(cfg_ready), 32'd1);
        rst = 1'b0;
        step();

        // Fast ramp: freq=0, one update per cycle.
        do_cfg(8'd0, 3'd2, 8'd0, 1'b0);
        check("fast_sel_cfg", 32'(select), 32'd2);
        do_start();
        check("fast_busy", 32'(busy), 32'd1);
        check("fast_count0", 32'(count), 32'd0);
        for (int i = 1; i <= 256; i++) begin
            step();
            check("fast_count", 32'(count), 32'(i % 256));
            check("fast_tick", 32'(tick), 32'd1);
            check("fast_pd", 32'(period_done), 32'(i == 256));
            check("fast_sel", 32'(select), 32'd2);
        end
        $display("fast ramp wrapped: count=0x%0h pd=%0d", count, period_done);
        do_stop();
        wait_idle(300);

        // Prescaled ramp: freq=3, one update every 4 cycles.
        do_cfg(8'd3, 3'd1, 8'd0, 1'b0);
        do_start();
        for (int j = 1; j <= 1024; j++) begin
            step();
            check("pre_count", 32'(count), 32'((j / 4) % 256));
            check("pre_tick", 32'(tick), 32'(j % 4 == 0));
            check("pre_pd", 32'(period_done), 32'(j == 1024));
        end
        $display("prescaled ramp wrapped: count=0x%0h pd=%0d", count, period_done);
        do_stop();
        wait_idle(1100);

        // Auto-advance: sel 5,5,6,6,0,0,1 per period (7 skipped).
        do_cfg(8'd0, 3'd5, 8'd1, 1'b1);
        do_start();
        for (int j = 1; j <= 1536; j++) begin
            step();
            check("auto_sel", 32'(select), 32'(seq[j / 256]));
            check("auto_pd", 32'(period_done), 32'(j % 256 == 0));
        end
        $display("auto advance done: select=%0d", select);
        do_stop();
        wait_idle(300);

        // Mid-run reconfiguration.
        do_cfg(8'd0, 3'd2, 8'd0, 1'b0);
        do_start();
        repeat (64) step();
        check("mid_count40", 32'(count), 32'h40);
        check("mid_ready_pre", 32'(cfg_ready), 32'd1);
        cfg_valid = 1'b1;
        cfg_freq = 8'd1;
        cfg_select = 3'd3;
        cfg_dwell = 8'd0;
        cfg_auto = 1'b0;
        step();
        check("mid_ready_drop", 32'(cfg_ready), 32'd0);
        check("mid_count41", 32'(count), 32'h41);
        $display("mid-run offer accepted at count 0x40, cfg_ready=%0d", cfg_ready);
        cfg_freq = 8'd0;
        cfg_select = 3'd4;
        for (int c = 'h42; c <= 256; c++) begin
            step();
            if (c < 256) begin
                check("mid_stall_ready", 32'(cfg_ready), 32'd0);
                check("mid_old_sel", 32'(select), 32'd2);
            end
        end
        check("mid_wrap_count", 32'(count), 32'd0);
        check("mid_wrap_sel", 32'(select), 32'd3);
        check("mid_wrap_pd", 32'(period_done), 32'd1);
        check("mid_wrap_ready", 32'(cfg_ready), 32'd1);
        $display("mid-run wrap: select=%0d cfg_ready=%0d", select, cfg_ready);
        step();
        check("mid_second_ready", 32'(cfg_ready), 32'd0);
        check("mid_slow_count", 32'(count), 32'd0);
        cfg_valid = 1'b0;
        for (int j = 2; j <= 512; j++) begin
            step();
            check("mid_slow_count", 32'(count), 32'((j / 2) % 256));
            check("mid_slow_tick", 32'(tick), 32'(j % 2 == 0));
            check("mid_slow_pd", 32'(period_done), 32'(j == 512));
        end
        check("mid_second_sel", 32'(select), 32'd4);
        check("mid_ready_back", 32'(cfg_ready), 32'd1);
        $display("512-cycle period done: select=%0d", select);
        do_stop();
        wait_idle(300);

        // Stop at 0x80 runs to the end of the period.
        do_cfg(8'd0, 3'd0, 8'd0, 1'b0);
        do_start();
        repeat (128) step();
        check("stop_count80", 32'(count), 32'h80);
        do_stop();
        for (int c = 'h81; c <= 'hFF; c++) begin
            check("stop_busy", 32'(busy), 32'd1);
            check("stop_count", 32'(count), 32'(c));
            step();
        end
        check("stop_end_count", 32'(count), 32'd0);
        check("stop_end_busy", 32'(busy), 32'd0);
        check("stop_end_pd", 32'(period_done), 32'd1);
        check("stop_end_tick", 32'(tick), 32'd1);
        step();
        check("stop_idle_tick", 32'(tick), 32'd0);
        check("stop_idle_count", 32'(count), 32'd0);
        $display("stopped at wrap: busy=%0d count=0x%0h", busy, count);

        // Stop then cancel with start: keeps running through wraps.
        do_start();
        repeat (128) step();
        do_stop();
        repeat (15) step();
        check("cancel_count", 32'(count), 32'h90);
        do_start();
        exp_cnt = 'h91;
        for (int k = 0; k < 600; k++) begin
            check("cancel_busy", 32'(busy), 32'd1);
            check("cancel_count", 32'(count), 32'(exp_cnt));
            step();
            exp_cnt = (exp_cnt + 1) % 256;
        end
        $display("cancel kept running: busy=%0d", busy);
        do_stop();
        wait_idle(300);

        // Asynchronous reset mid-run with a pending configuration.
        do_cfg(8'd0, 3'd3, 8'd0, 1'b0);
        do_start();
        repeat (90) step();
        check("rstrun_count", 32'(count), 32'h5A);
        cfg_valid = 1'b1;
        cfg_freq = 8'd2;
        cfg_select = 3'd6;
        step();
        cfg_valid = 1'b0;
        check("rstrun_pend", 32'(cfg_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_select", 32'(select), 32'd0);
        check("arst_tick", 32'(tick), 32'd0);
        check("arst_pd", 32'(period_done), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_ready", 32'(cfg_ready), 32'd1);
        $display("async reset mid-run: count=0x%0h busy=%0d", count, busy);
        step();
        rst = 1'b0;
        step();
        do_start();
        repeat (5) step();
        check("post_rst_count", 32'(count), 32'd5);
        check("post_rst_sel", 32'(select), 32'd0);
        repeat (251) step();
        check("post_rst_wrap_count", 32'(count), 32'd0);
        check("post_rst_wrap_pd", 32'(period_done), 32'd1);
        check("post_rst_wrap_sel", 32'(select), 32'd0);
        $display("post-reset wrap: select=%0d", select);
        do_stop();
        wait_idle(300);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
